axi_read_port_scheduler: RTL and testbench

- Shares one slave-side AXI read channel (AR + R) between two masters, M0 and M1; one instance per slave port (S0, S1, default slave) in the AXI interconnect.
- Arbitrates AR requests round-robin and forwards the granted AR with the slave ID extended by the master index.
- Locks the grant until the last R beat of that burst has been accepted; routes R beats back by grant.
- Checks burst length and returned ID, and reports violations through sticky error flags.

---
 rtl/axi_read_port_scheduler_pkg.sv | 16 +
 rtl/axi_read_port_scheduler_rr_pick2.sv | 18 +
 rtl/axi_read_port_scheduler.sv | 171 +++++++++++++++++
 tb/tb_axi_read_port_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_port_scheduler_pkg.sv
// Shared types for the two-master AXI read port scheduler.
package axi_read_port_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Master index; also used for the round-robin priority pointer.
    typedef logic pointer_t;

    localparam pointer_t M0 = 1'b0;
    localparam pointer_t M1 = 1'b1;

endpackage

// File: rtl/axi_read_port_scheduler_rr_pick2.sv
// rr_pick2: two-request round-robin picker; the priority master wins only on a tie.
module axi_read_port_scheduler_rr_pick2
    import axi_read_port_scheduler_pkg::*;
(
    input  logic [1:0] req,
    input  pointer_t   prio,
    output pointer_t   gnt
);

    always_comb begin
        gnt = M0;
        if (req == 2'b11)
            gnt = prio;
        else if (req[1])
            gnt = M1;
    end

endmodule

// File: rtl/axi_read_port_scheduler.sv
// Shares one slave AXI read channel between two masters: round-robin AR grant,
// grant held until RLAST, R routed back by grant, sticky length/ID error flags.
module axi_read_port_scheduler
    import axi_read_port_scheduler_pkg::*;
#(
    parameter int IDM_BITS  = 4,
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 3,
    parameter int DATA_BITS = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,

    input  logic [IDM_BITS-1:0]  ARID_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    input  logic [LEN_BITS-1:0]  ARLEN_M0,
    input  logic [SIZE_BITS-1:0] ARSIZE_M0,
    input  logic [1:0]           ARBURST_M0,
    input  logic                 ARVALID_M0,
    output logic                 ARREADY_M0,
    output logic [IDM_BITS-1:0]  RID_M0,
    output logic [DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]           RRESP_M0,
    output logic                 RLAST_M0,
    output logic                 RVALID_M0,
    input  logic                 RREADY_M0,

    input  logic [IDM_BITS-1:0]  ARID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    input  logic [LEN_BITS-1:0]  ARLEN_M1,
    input  logic [SIZE_BITS-1:0] ARSIZE_M1,
    input  logic [1:0]           ARBURST_M1,
    input  logic                 ARVALID_M1,
    output logic                 ARREADY_M1,
    output logic [IDM_BITS-1:0]  RID_M1,
    output logic [DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]           RRESP_M1,
    output logic                 RLAST_M1,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M1,

    output logic [IDS_BITS-1:0]  ARID_S,
    output logic [ADDR_BITS-1:0] ARADDR_S,
    output logic [LEN_BITS-1:0]  ARLEN_S,
    output logic [SIZE_BITS-1:0] ARSIZE_S,
    output logic [1:0]           ARBURST_S,
    output logic                 ARVALID_S,
    input  logic                 ARREADY_S,
    input  logic [IDS_BITS-1:0]  RID_S,
    input  logic [DATA_BITS-1:0] RDATA_S,
    input  logic [1:0]           RRESP_S,
    input  logic                 RLAST_S,
    input  logic                 RVALID_S,
    output logic                 RREADY_S,

    output logic                 ERR_LEN,
    output logic                 ERR_ID
);

    localparam logic [LEN_BITS:0] CNT_MAX = {1'b1, {LEN_BITS{1'b0}}};

    state_t                state;
    pointer_t              grant;
    pointer_t              prio;
    pointer_t              pick;
    logic [LEN_BITS-1:0]   exp_len;
    logic [IDS_BITS-1:0]   exp_id;
    logic [LEN_BITS:0]     beat_cnt;
    logic                  err_len;
    logic                  err_id;

    logic                  in_addr;
    logic                  sel0;
    logic                  sel1;
    logic                  beat;
    logic [IDM_BITS-1:0]   arid_g;
    logic [IDS_BITS-1:0]   arid_ext;
    logic [LEN_BITS-1:0]   arlen_g;

    axi_read_port_scheduler_rr_pick2 u_pick (
        .req  ({ARVALID_M1, ARVALID_M0}),
        .prio (prio),
        .gnt  (pick)
    );

    assign in_addr  = (state == ADDR);
    assign sel0     = (state == DATA) && (grant == M0);
    assign sel1     = (state == DATA) && (grant == M1);

    assign arid_g   = (grant == M1) ? ARID_M1 : ARID_M0;
    assign arlen_g  = (grant == M1) ? ARLEN_M1 : ARLEN_M0;
    // Master index lands just above the master ID; upper bits stay zero.
    assign arid_ext = IDS_BITS'({grant, arid_g});

    // Payloads are gated to zero outside their phase so idle outputs are quiet.
    assign ARVALID_S  = in_addr;
    assign ARID_S     = in_addr ? arid_ext : '0;
    assign ARLEN_S    = in_addr ? arlen_g : '0;
    assign ARADDR_S   = in_addr ? ((grant == M1) ? ARADDR_M1 : ARADDR_M0) : '0;
    assign ARSIZE_S   = in_addr ? ((grant == M1) ? ARSIZE_M1 : ARSIZE_M0) : '0;
    assign ARBURST_S  = in_addr ? ((grant == M1) ? ARBURST_M1 : ARBURST_M0) : '0;
    assign ARREADY_M0 = in_addr && (grant == M0) && ARREADY_S;
    assign ARREADY_M1 = in_addr && (grant == M1) && ARREADY_S;

    assign RVALID_M0  = sel0 & RVALID_S;
    assign RLAST_M0   = sel0 & RLAST_S;
    assign RID_M0     = sel0 ? RID_S[IDM_BITS-1:0] : '0;
    assign RDATA_M0   = sel0 ? RDATA_S : '0;
    assign RRESP_M0   = sel0 ? RRESP_S : '0;
    assign RVALID_M1  = sel1 & RVALID_S;
    assign RLAST_M1   = sel1 & RLAST_S;
    assign RID_M1     = sel1 ? RID_S[IDM_BITS-1:0] : '0;
    assign RDATA_M1   = sel1 ? RDATA_S : '0;
    assign RRESP_M1   = sel1 ? RRESP_S : '0;

    // Slave R stalls outside DATA so stray beats are held, not dropped.
    assign RREADY_S   = (sel0 & RREADY_M0) | (sel1 & RREADY_M1);
    assign beat       = RVALID_S & RREADY_S;

    assign ERR_LEN    = err_len;
    assign ERR_ID     = err_id;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= IDLE;
            grant    <= M0;
            prio     <= M0;
            exp_len  <= '0;
            exp_id   <= '0;
            beat_cnt <= '0;
            err_len  <= 1'b0;
            err_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ARVALID_M0 || ARVALID_M1) begin
                        grant <= pick;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ARREADY_S) begin
                        exp_len  <= arlen_g;
                        exp_id   <= arid_ext;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        if (beat_cnt != CNT_MAX)
                            beat_cnt <= beat_cnt + 1'b1;
                        if (RID_S != exp_id)
                            err_id <= 1'b1;
                        // RLAST must coincide exactly with beat index LEN.
                        if (RLAST_S != (beat_cnt == {1'b0, exp_len}))
                            err_len <= 1'b1;
                        if (RLAST_S) begin
                            prio  <= ~grant;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_port_scheduler.sv
// Directed bench: per-cycle vector table plus hand sequences for stall, length and reset cases.
module tb_axi_read_port_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
    logic [7:0]  ARID_S, RID_S;
    logic [31:0] ARADDR_S, RDATA_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S, RRESP_S;
    logic        ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;
    logic        ERR_LEN, ERR_ID;

    axi_read_port_scheduler dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .ERR_LEN(ERR_LEN), .ERR_ID(ERR_ID)
    );

    typedef struct {
        int          arv0, arv1, ars, rvs, rlast, rid, rr0, rr1;
        logic [27:0] exp;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl [26];

    // Order: ARVALID_S, ARID_S, ARLEN_S, ARREADY_M0/M1, RVALID_M0/M1, RREADY_S, RID_M0, RID_M1, ERR_LEN, ERR_ID
    function automatic logic [27:0] ex(input int arv, arid, arlen, a0, a1, v0, v1, rrs, r0, r1, el, ei);
        return {1'(arv), 8'(arid), 4'(arlen), 1'(a0), 1'(a1), 1'(v0), 1'(v1), 1'(rrs),
                4'(r0), 4'(r1), 1'(el), 1'(ei)};
    endfunction

    function automatic vec_t mkv(input int arv0, arv1, ars, rvs, rlast, rid, rr0, rr1,
                                 input logic [27:0] e);
        vec_t v;
        v.arv0 = arv0; v.arv1 = arv1; v.ars = ars; v.rvs = rvs; v.rlast = rlast;
        v.rid = rid; v.rr0 = rr0; v.rr1 = rr1; v.exp = e;
        return v;
    endfunction

    logic [27:0] act;
    assign act = {ARVALID_S, ARID_S, ARLEN_S, ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1,
                  RREADY_S, RID_M0, RID_M1, ERR_LEN, ERR_ID};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        int beats;
        logic rr1;
        logic [31:0] d;

        //            arv0 arv1 ars rvs last rid   rr0 rr1   ARV ARID  LEN A0 A1 V0 V1 RRS R0  R1  EL EI
        tbl[0]  = mkv(0, 0, 0, 0, 0, 'h00, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 0, 0, 0,   0,   0, 0));
        tbl[1]  = mkv(1, 1, 0, 0, 0, 'h00, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 0, 0, 0,   0,   0, 0));
        tbl[2]  = mkv(1, 1, 0, 0, 0, 'h00, 1, 1, ex(1, 'h05, 3, 0, 0, 0, 0, 0, 0,   0,   0, 0));
        tbl[3]  = mkv(1, 1, 1, 0, 0, 'h00, 1, 1, ex(1, 'h05, 3, 1, 0, 0, 0, 0, 0,   0,   0, 0));
        tbl[4]  = mkv(0, 1, 0, 1, 0, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   0, 0));
        tbl[5]  = mkv(0, 1, 0, 1, 0, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   0, 0));
        tbl[6]  = mkv(0, 1, 0, 0, 0, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 0, 1, 5,   0,   0, 0));
        tbl[7]  = mkv(0, 1, 0, 1, 0, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   0, 0));
        tbl[8]  = mkv(0, 1, 0, 1, 1, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   0, 0));
        tbl[9]  = mkv(1, 1, 0, 0, 0, 'h00, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 0, 0, 0,   0,   0, 0));
        tbl[10] = mkv(1, 1, 1, 0, 0, 'h00, 1, 1, ex(1, 'h1A, 1, 0, 1, 0, 0, 0, 0,   0,   0, 0));
        tbl[11] = mkv(1, 1, 0, 1, 0, 'h1A, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 1, 1, 0, 'hA,   0, 0));
        tbl[12] = mkv(1, 1, 0, 1, 1, 'h1A, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 1, 1, 0, 'hA,   0, 0));
        tbl[13] = mkv(1, 1, 0, 0, 0, 'h00, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 0, 0, 0,   0,   0, 0));
        tbl[14] = mkv(1, 1, 1, 0, 0, 'h00, 1, 1, ex(1, 'h05, 3, 1, 0, 0, 0, 0, 0,   0,   0, 0));
        tbl[15] = mkv(0, 1, 0, 1, 0, 'h05, 1, 0, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   0, 0));
        tbl[16] = mkv(0, 1, 0, 1, 0, 'h13, 1, 0, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 3,   0,   0, 0));
        tbl[17] = mkv(0, 1, 0, 1, 1, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   0, 1));
        tbl[18] = mkv(0, 0, 0, 1, 0, 'h00, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 0, 0, 0,   0,   1, 1));
        tbl[19] = mkv(1, 0, 0, 0, 0, 'h00, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 0, 0, 0,   0,   1, 1));
        tbl[20] = mkv(1, 0, 1, 0, 0, 'h00, 1, 1, ex(1, 'h05, 3, 1, 0, 0, 0, 0, 0,   0,   1, 1));
        tbl[21] = mkv(0, 0, 0, 1, 0, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   1, 1));
        tbl[22] = mkv(0, 0, 0, 1, 0, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   1, 1));
        tbl[23] = mkv(0, 0, 0, 1, 0, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   1, 1));
        tbl[24] = mkv(0, 0, 0, 1, 1, 'h05, 1, 1, ex(0, 'h00, 0, 0, 0, 1, 0, 1, 5,   0,   1, 1));
        tbl[25] = mkv(0, 0, 0, 0, 0, 'h00, 1, 1, ex(0, 'h00, 0, 0, 0, 0, 0, 0, 0,   0,   1, 1));

        ARID_M0 = 4'h5; ARID_M1 = 4'hA; ARLEN_M0 = 4'd3; ARLEN_M1 = 4'd1;
        ARADDR_M0 = 32'h0000_1000; ARADDR_M1 = 32'h0000_2000;
        ARSIZE_M0 = 3'd2; ARSIZE_M1 = 3'd2; ARBURST_M0 = 2'd1; ARBURST_M1 = 2'd1;
        ARVALID_M0 = 0; ARVALID_M1 = 0; RREADY_M0 = 0; RREADY_M1 = 0;
        ARREADY_S = 0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 0; RVALID_S = 0;
        repeat (2) @(negedge ACLK);
        check("reset_state", 64'(act), 64'(0));
        ARESETn = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge ACLK);
            ARVALID_M0 = tbl[i].arv0[0]; ARVALID_M1 = tbl[i].arv1[0]; ARREADY_S = tbl[i].ars[0];
            RVALID_S = tbl[i].rvs[0]; RLAST_S = tbl[i].rlast[0]; RID_S = tbl[i].rid[7:0];
            RREADY_M0 = tbl[i].rr0[0]; RREADY_M1 = tbl[i].rr1[0];
            RDATA_S = 32'hD000_0000 + 32'(i);
            #1 check($sformatf("row%0d", i), 64'(act), 64'(tbl[i].exp));
        end

        // Reset clears sticky flags and all outputs.
        @(negedge ACLK);
        ARVALID_M0 = 0; ARVALID_M1 = 0; ARREADY_S = 0; RVALID_S = 0; RLAST_S = 0;
        ARESETn = 1'b0;
        #1 check("rst_clear", 64'(act), 64'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;

        // M1 burst of 4 with RREADY_M1 stalled for 3 cycles after beat 0.
        ARLEN_M1 = 4'd3; ARSIZE_M1 = 3'd5; ARBURST_M1 = 2'd2;
        @(negedge ACLK);
        ARVALID_M1 = 1;
        @(negedge ACLK);
        ARREADY_S = 1;
        #1 check("stall_ar", 64'({ARVALID_S, ARID_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARREADY_M1, ARREADY_M0}),
                 64'({1'b1, 8'h1A, 4'd3, 3'd5, 2'd2, 1'b1, 1'b0}));
        check("stall_araddr", 64'(ARADDR_S), 64'h2000);
        beats = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge ACLK);
            ARVALID_M1 = 0; ARREADY_S = 0;
            rr1 = (c == 0) || (c >= 4);
            d = 32'hC0DE_0000 + 32'(beats);
            RVALID_S = 1; RLAST_S = (c == 6); RID_S = 8'h1A; RDATA_S = d; RRESP_S = 2'b01;
            RREADY_M1 = rr1;
            #1 check($sformatf("stall_c%0d", c),
                     64'({RREADY_S, RVALID_M1, RVALID_M0, RRESP_M1, RDATA_M1}),
                     64'({rr1, 1'b1, 1'b0, 2'b01, d}));
            if (rr1 && RVALID_M1) beats++;
        end
        check("stall_beats", 64'(beats), 64'(4));
        @(negedge ACLK);
        RLAST_S = 0;
        #1 check("stray_stalled", 64'({RREADY_S, RVALID_M1, ERR_LEN, ERR_ID}), 64'(0));

        // ARLEN=1 but beat 1 arrives without RLAST.
        @(negedge ACLK);
        RVALID_S = 0; ARLEN_M0 = 4'd1; ARVALID_M0 = 1;
        @(negedge ACLK);
        ARREADY_S = 1;
        #1 check("len_arid", 64'(ARID_S), 64'h05);
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            ARVALID_M0 = 0; ARREADY_S = 0;
            RVALID_S = 1; RID_S = 8'h05; RREADY_M0 = 1; RLAST_S = (c == 2);
            #1 check($sformatf("len_b%0d", c), 64'({RVALID_M0, ERR_LEN, ERR_ID}),
                     64'({1'b1, c == 2, 1'b0}));
        end
        @(negedge ACLK);
        RVALID_S = 0; RLAST_S = 0;
        #1 check("len_sticky", 64'({RVALID_M0, RREADY_S, ERR_LEN}), 64'({1'b0, 1'b0, 1'b1}));

        // Reset during beat 1 of an M0 burst, with priority currently at M1.
        @(negedge ACLK);
        ARVALID_M0 = 1;
        @(negedge ACLK);
        ARREADY_S = 1;
        @(negedge ACLK);
        ARVALID_M0 = 0; ARREADY_S = 0; RVALID_S = 1;
        @(negedge ACLK);
        #1 check("mid_beat1", 64'({RVALID_M0, RREADY_S}), 64'({1'b1, 1'b1}));
        ARESETn = 1'b0;
        #1 check("mid_reset", 64'({ARVALID_S, ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1, RREADY_S, ERR_LEN, ERR_ID}),
                 64'(0));
        RVALID_S = 0;
        @(negedge ACLK);
        ARESETn = 1'b1; ARVALID_M0 = 1; ARVALID_M1 = 1;
        #1 check("post_rst_idle", 64'(ARVALID_S), 64'(0));
        @(negedge ACLK);
        #1 check("post_rst_prio", 64'({ARVALID_S, ARID_S}), 64'({1'b1, 8'h05}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
